// File: rtl/spi_slave_regs.sv
// spi_slave_regs -- SPI mode-0 responder with a small byte register file.
//
// The far end of the APB-programmed SPI master. Each transaction under a
// low chip select is an address byte followed by a data byte, both LSB
// first and sampled on the SPI clock's rising edge. Address bit 7 selects
// write (1) or read (0); bits [3:0] index the register file. Several
// transactions may follow each other under one chip select. All SPI pins
// are oversampled in the pclk_i domain.
//
// Ports:
//   pclk_i, prst_i       system clock, asynchronous active-high reset
//   sclk_i, cs_n_i,      SPI clock, chip select (active low), master data
//   mosi_i
//   miso_o, miso_oe_o    slave data and its drive enable (read data phase)
//   wr_strobe_o          one-cycle pulse when an SPI write commits
//   wr_addr_o, wr_data_o index/data of the last committed write (held)
//   frame_err_o          one-cycle pulse when chip select rose mid-byte
//   rd_addr_i, rd_data_o local read port, one cycle of latency
module spi_slave_regs #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk_i,
  input  logic       prst_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic       wr_strobe_o,
  output logic [3:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       frame_err_o,
  input  logic [3:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ADDR = 3'b010,
    S_DATA = 3'b100
  } state_e;

  // ---------------------------------------------------------------------
  // Input synchronizers plus one history flop for edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours; blocking here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, sclk_i});
      cs_sync_q   <= SYNC_STAGES'({cs_sync_q, cs_n_i});
      mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, mosi_i});
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  // SCLK edges only count while the synced chip select is low.
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // ---------------------------------------------------------------------
  // Frame FSM and datapath
  // ---------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shin_q, shin_d;      // last seven received bits
  logic        is_wr_q, is_wr_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  shout_q, shout_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  byte_in;
  logic        commit;

  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  rd_data_q;

  // The byte as it stands once the bit arriving on this rise is included.
  assign byte_in = {mosi_s, shin_q};

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shin_d      = shin_q;
    is_wr_d     = is_wr_q;
    idx_d       = idx_q;
    shout_d     = shout_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;

    if (cs_s) begin
      // Chip select released: abandon any partial byte without committing.
      if (state_q != S_IDLE) begin
        state_d     = S_IDLE;
        frame_err_d = (cnt_q != 3'd0);
      end
      cnt_d  = 3'd0;
      miso_d = 1'b0;
      oe_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            shin_d = byte_in[7:1];
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              is_wr_d = byte_in[7];
              idx_d   = byte_in[3:0];
              state_d = S_DATA;
              if (!byte_in[7]) shout_d = regs_q[byte_in[IDX_W-1:0]];
            end
          end
        end
        S_DATA: begin
          if (sclk_rise) begin
            shin_d = byte_in[7:1];
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = S_ADDR;
              miso_d  = 1'b0;
              oe_d    = 1'b0;
              if (is_wr_q) begin
                commit      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = idx_q;
                wr_data_d   = byte_in;
              end
            end
          end else if (sclk_fall && !is_wr_q) begin
            // Mode 0: present the next bit on the fall so it is stable
            // before the master samples it on the following rise.
            miso_d  = shout_q[0];
            oe_d    = 1'b1;
            shout_d = {1'b0, shout_q[7:1]};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      shin_q      <= '0;
      is_wr_q     <= 1'b0;
      idx_q       <= '0;
      shout_q     <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shin_q      <= shin_d;
      is_wr_q     <= is_wr_d;
      idx_q       <= idx_d;
      shout_q     <= shout_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Register file and local read port
  // ---------------------------------------------------------------------
  // NOTE: the register file has a defined power-on value, so it is reset
  // like ordinary flops rather than left as an unreset memory array.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (commit) regs_q[idx_q[IDX_W-1:0]] <= byte_in;
      // Reads the pre-commit value when the same register is written.
      rd_data_q <= regs_q[rd_addr_i[IDX_W-1:0]];
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe_o   = oe_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_err_o = frame_err_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed testbench for spi_slave_regs: acts as a mode-0 SPI master,
// keeps its own copy of the expected register contents and checks the
// SPI, strobe, error and local-read behaviour against it.
module tb_spi_slave_regs;

  logic       pclk_i = 1'b0;
  logic       prst_i;
  logic       sclk_i;
  logic       cs_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;
  logic       wr_strobe_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       frame_err_o;
  logic [3:0] rd_addr_i;
  logic [7:0] rd_data_o;

  spi_slave_regs dut (
    .pclk_i      (pclk_i),
    .prst_i      (prst_i),
    .sclk_i      (sclk_i),
    .cs_n_i      (cs_n_i),
    .mosi_i      (mosi_i),
    .miso_o      (miso_o),
    .miso_oe_o   (miso_oe_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .frame_err_o (frame_err_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  always #5 pclk_i = ~pclk_i;

  int         total = 0;
  int         bad   = 0;
  int         half  = 4;               // SCLK half period in pclk cycles
  logic [7:0] exp_regs [16];

  // Cycle counts of the pulse outputs, plus what each strobe carried.
  int         strobe_cycles = 0;
  int         ferr_cycles   = 0;
  logic [3:0] mon_addr = '0;
  logic [7:0] mon_data = '0;

  always @(negedge pclk_i) begin
    if (wr_strobe_o === 1'b1) begin
      strobe_cycles++;
      mon_addr = wr_addr_o;
      mon_data = wr_data_o;
    end
    if (frame_err_o === 1'b1) ferr_cycles++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shift nbits of tx out LSB first; rx collects MISO just before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic oe_all, output logic oe_any);
    rx = '0;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi_i = tx[i];
      repeat (half) @(negedge pclk_i);
      rx[i]  = miso_o;
      oe_all = oe_all & miso_oe_o;
      oe_any = oe_any | miso_oe_o;
      sclk_i = 1'b1;
      repeat (half) @(negedge pclk_i);
      sclk_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n_i = 1'b0;
    repeat (6) @(negedge pclk_i);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge pclk_i);
    cs_n_i = 1'b1;
    repeat (8) @(negedge pclk_i);
  endtask

  task automatic spi_write(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] rx;
    logic       a, b;
    spi_bits(addr, 8, rx, a, b);
    spi_bits(data, 8, rx, a, b);
    exp_regs[addr[3:0]] = data;
  endtask

  task automatic local_read(input logic [3:0] idx, input string tag);
    rd_addr_i = idx;
    @(negedge pclk_i);
    check(tag, rd_data_o, exp_regs[idx]);
  endtask

  initial begin
    logic [7:0] rx;
    logic       oe_all, oe_any;
    int         s0, f0;
    logic [3:0] ridx;
    logic [7:0] rdat;

    prst_i = 1'b1; sclk_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0; rd_addr_i = '0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;

    // ---- reset state ----
    repeat (3) @(negedge pclk_i);
    check("rst_miso", miso_o, 0);
    check("rst_oe", miso_oe_o, 0);
    check("rst_strobe", wr_strobe_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_rd_data", rd_data_o, 0);
    prst_i = 1'b0;
    repeat (2) @(negedge pclk_i);
    for (int i = 0; i < 16; i++) local_read(4'(i), $sformatf("rst_reg%0d", i));

    // ---- single write 0x83 / 0x46 ----
    s0 = strobe_cycles; f0 = ferr_cycles;
    cs_low();
    spi_write(8'h83, 8'h46);
    cs_high();
    check("wr1_strobes", strobe_cycles - s0, 1);
    check("wr1_addr", mon_addr, 4'h3);
    check("wr1_data", mon_data, 8'h46);
    check("wr1_hold_addr", wr_addr_o, 4'h3);
    check("wr1_hold_data", wr_data_o, 8'h46);
    check("wr1_ferr", ferr_cycles - f0, 0);
    local_read(4'h3, "wr1_reg3");

    // ---- SPI read of register 3 ----
    s0 = strobe_cycles;
    cs_low();
    spi_bits(8'h03, 8, rx, oe_all, oe_any);
    check("rd_addr_phase_oe", oe_any, 0);
    spi_bits(8'h00, 8, rx, oe_all, oe_any);
    check("rd_data", rx, 8'h46);
    check("rd_oe_held", oe_all, 1);
    check("rd_oe_after", miso_oe_o, 0);
    check("rd_miso_after", miso_o, 0);
    cs_high();
    check("rd_no_strobe", strobe_cycles - s0, 0);
    local_read(4'h3, "rd_reg3_kept");

    // ---- burst of 8 writes under one chip select ----
    s0 = strobe_cycles; f0 = ferr_cycles;
    cs_low();
    for (int i = 0; i < 8; i++) spi_write(8'h80 + 8'(i), 8'hD3 + 8'(i));
    cs_high();
    check("burst_strobes", strobe_cycles - s0, 8);
    check("burst_last_addr", mon_addr, 4'h7);
    check("burst_last_data", mon_data, 8'hDA);
    check("burst_ferr", ferr_cycles - f0, 0);
    for (int i = 0; i < 8; i++) local_read(4'(i), $sformatf("burst_reg%0d", i));

    // ---- aborted write: cs_n rises after 5 data bits ----
    s0 = strobe_cycles; f0 = ferr_cycles;
    cs_low();
    spi_bits(8'h85, 8, rx, oe_all, oe_any);
    spi_bits(8'hAA, 5, rx, oe_all, oe_any);
    cs_high();
    check("abort_ferr_pulse", ferr_cycles - f0, 1);
    check("abort_no_strobe", strobe_cycles - s0, 0);
    local_read(4'h5, "abort_reg5_kept");
    s0 = strobe_cycles; f0 = ferr_cycles;
    cs_low();
    spi_write(8'h85, 8'h5C);
    cs_high();
    check("post_abort_strobe", strobe_cycles - s0, 1);
    check("post_abort_ferr", ferr_cycles - f0, 0);
    local_read(4'h5, "post_abort_reg5");

    // ---- random data at minimum and wider SCLK ratios ----
    s0 = strobe_cycles;
    half = 4;
    cs_low();
    for (int i = 0; i < 4; i++) begin
      ridx = 4'($urandom_range(0, 15));
      rdat = 8'($urandom);
      spi_write({1'b1, 3'($urandom), ridx}, rdat);
    end
    cs_high();
    half = 7;
    cs_low();
    for (int i = 0; i < 3; i++) begin
      ridx = 4'($urandom_range(0, 15));
      rdat = 8'($urandom);
      spi_write({1'b1, 3'b000, ridx}, rdat);
    end
    cs_high();
    check("rand_strobes", strobe_cycles - s0, 7);
    for (int i = 0; i < 16; i++) local_read(4'(i), $sformatf("rand_reg%0d", i));
    half = 4;
    cs_low();
    spi_bits({4'b0000, ridx}, 8, rx, oe_all, oe_any);
    spi_bits(8'($urandom), 8, rx, oe_all, oe_any);
    cs_high();
    check("rand_spi_read", rx, exp_regs[ridx]);

    // ---- reset mid-frame ----
    cs_low();
    spi_bits(8'h82, 8, rx, oe_all, oe_any);
    spi_bits(8'hFF, 3, rx, oe_all, oe_any);
    @(posedge pclk_i);
    #3 prst_i = 1'b1;
    #1;
    check("midrst_wr_addr", wr_addr_o, 0);
    check("midrst_wr_data", wr_data_o, 0);
    check("midrst_rd_data", rd_data_o, 0);
    cs_n_i = 1'b1; sclk_i = 1'b0;
    repeat (3) @(negedge pclk_i);
    prst_i = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    repeat (2) @(negedge pclk_i);
    local_read(4'h0, "midrst_reg0");
    local_read(4'h3, "midrst_reg3");
    local_read(4'h5, "midrst_reg5");
    s0 = strobe_cycles; f0 = ferr_cycles;
    cs_low();
    spi_write(8'h82, 8'h11);
    cs_high();
    check("midrst_next_strobe", strobe_cycles - s0, 1);
    check("midrst_next_ferr", ferr_cycles - f0, 0);
    local_read(4'h2, "midrst_next_reg2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
